// File: rtl/gpio_chaser.sv
// Memory-mapped LED/GPIO pattern sequencer: a programmable prescaler advances a
// rotate/bounce/hold pattern, with output invert and a sticky cycle-complete flag.
module gpio_chaser #(
  parameter int WIDTH       = 8,
  parameter int CNT_WIDTH   = 24,
  parameter int DEFAULT_DIV = 6000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       address,
  input  logic [31:0]      write_data,
  input  logic             we,
  input  logic             re,
  output logic [31:0]      read_data,
  output logic [WIDTH-1:0] led_out,
  output logic             step_pulse,
  output logic             cycle_irq
);

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'b00,
    MODE_ROTR   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'b00,
    REG_DIV    = 2'b01,
    REG_SEED   = 2'b10,
    REG_STATUS = 2'b11
  } reg_t;

  logic                 en;
  mode_t                mode;
  logic                 inv;
  logic [CNT_WIDTH-1:0] div;
  logic [WIDTH-1:0]     seed;
  logic [WIDTH-1:0]     pattern;
  logic                 dir;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 wrap;

  reg_t                 reg_sel;
  logic                 wr_ctrl, wr_div, wr_seed, wr_status;
  logic                 terminal;
  logic                 step;
  logic [WIDTH-1:0]     pat_next;
  logic                 dir_next;
  logic [31:0]          rd_mux;

  assign reg_sel   = reg_t'(address[3:2]);
  assign wr_ctrl   = we && (reg_sel == REG_CTRL);
  assign wr_div    = we && (reg_sel == REG_DIV);
  assign wr_seed   = we && (reg_sel == REG_SEED);
  assign wr_status = we && (reg_sel == REG_STATUS);

  // ">=" rather than "==" so lowering DIV below the running count steps at once.
  assign terminal  = (cnt >= div);
  // A SEED write reloads the pattern and restarts the period, so it suppresses the step.
  assign step      = en && terminal && !wr_seed;

  assign cycle_irq = wrap;

  // NOTE: every always_comb output gets a default before any branch, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    pat_next = pattern;
    dir_next = dir;
    unique case (mode)
      MODE_ROTL: pat_next = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
      MODE_ROTR: pat_next = {pattern[0], pattern[WIDTH-1:1]};
      MODE_BOUNCE: begin
        if (!dir) begin
          if (pattern[WIDTH-1]) begin
            dir_next = 1'b1;
            pat_next = {1'b0, pattern[WIDTH-1:1]};
          end else begin
            pat_next = {pattern[WIDTH-2:0], 1'b0};
          end
        end else begin
          if (pattern[0]) begin
            dir_next = 1'b0;
            pat_next = {pattern[WIDTH-2:0], 1'b0};
          end else begin
            pat_next = {1'b0, pattern[WIDTH-1:1]};
          end
        end
      end
      MODE_HOLD: pat_next = pattern;
      default:   pat_next = pattern;
    endcase
  end

  // For WIDTH > 16 the wrap/dir bits overlay the upper pattern bits in STATUS.
  always_comb begin
    rd_mux = '0;
    unique case (reg_sel)
      REG_CTRL:   rd_mux[3:0] = {inv, mode, en};
      REG_DIV:    rd_mux[CNT_WIDTH-1:0] = div;
      REG_SEED:   rd_mux[WIDTH-1:0] = seed;
      REG_STATUS: begin
        rd_mux[WIDTH-1:0] = pattern;
        rd_mux[16]        = wrap;
        rd_mux[17]        = dir;
      end
      default:    rd_mux = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // here samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      en         <= 1'b0;
      mode       <= MODE_ROTL;
      inv        <= 1'b0;
      div        <= CNT_WIDTH'(DEFAULT_DIV - 1);
      seed       <= WIDTH'(1);
      pattern    <= WIDTH'(1);
      dir        <= 1'b0;
      cnt        <= '0;
      wrap       <= 1'b0;
      read_data  <= '0;
      led_out    <= '0;
      step_pulse <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en   <= write_data[0];
        mode <= mode_t'(write_data[2:1]);
        inv  <= write_data[3];
      end

      if (wr_div) div <= write_data[CNT_WIDTH-1:0];

      if (wr_seed) begin
        seed    <= write_data[WIDTH-1:0];
        pattern <= write_data[WIDTH-1:0];
        dir     <= 1'b0;
      end else if (step) begin
        pattern <= pat_next;
        dir     <= dir_next;
      end

      if (wr_seed || !en || terminal) cnt <= '0;
      else                            cnt <= cnt + CNT_WIDTH'(1);

      step_pulse <= step;

      // Set has priority over a software clear landing on the same edge.
      if (step && (pat_next == seed))         wrap <= 1'b1;
      else if (wr_status && write_data[16])   wrap <= 1'b0;

      if (re) read_data <= rd_mux;

      led_out <= en ? (pattern ^ {WIDTH{inv}}) : '0;
    end
  end

endmodule

// File: tb/tb_gpio_chaser.sv
// Directed bench for gpio_chaser (WIDTH=8): walks rotate/bounce/hold/invert modes
// and the prescaler, seed-write, wrap-clear and mid-run reset corner cases.
module tb_gpio_chaser;

  localparam int WIDTH       = 8;
  localparam int DEFAULT_DIV = 6000000;

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_DIV    = 4'h4;
  localparam logic [3:0] A_SEED   = 4'h8;
  localparam logic [3:0] A_STATUS = 4'hC;

  logic             clk;
  logic             rst;
  logic [3:0]       address;
  logic [31:0]      write_data;
  logic             we;
  logic             re;
  logic [31:0]      read_data;
  logic [WIDTH-1:0] led_out;
  logic             step_pulse;
  logic             cycle_irq;

  int               n_cmp;
  int               n_mis;
  logic [7:0]       exp_pat[$];
  logic [31:0]      rd;
  int               gap;
  int               steps_seen;

  gpio_chaser #(
    .WIDTH(WIDTH),
    .CNT_WIDTH(24),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .address(address),
    .write_data(write_data),
    .we(we),
    .re(re),
    .read_data(read_data),
    .led_out(led_out),
    .step_pulse(step_pulse),
    .cycle_irq(cycle_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    write_data = d;
    we         = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    re      = 1'b1;
    @(posedge clk);
    #1;
    re = 1'b0;
    d  = read_data;
  endtask

  task automatic bus_rw(input logic [3:0] a, input logic [31:0] d, output logic [31:0] q);
    @(negedge clk);
    address    = a;
    write_data = d;
    we         = 1'b1;
    re         = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    re = 1'b0;
    q  = read_data;
  endtask

  // Returns the number of edges until step_pulse is seen; a timeout is a failure.
  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!step_pulse && n < 300);
    if (!step_pulse) check("step_timeout", 32'd0, 32'd1);
  endtask

  // Runs exp_pat.size() steps at DIV=3: checks spacing, irq only on the last, led_out.
  task automatic run_steps(input string tag);
    int n;
    for (int i = 0; i < exp_pat.size(); i++) begin
      wait_step(n);
      check({tag, "_gap"}, 32'(n), (i == 0) ? 32'd4 : 32'd3);
      check({tag, "_irq"}, {31'd0, cycle_irq}, {31'd0, (i == exp_pat.size() - 1)});
      @(posedge clk);
      #1;
      check({tag, "_led"}, {24'd0, led_out}, {24'd0, exp_pat[i]});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1; we = 1'b0; re = 1'b0; address = '0; write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_led",   {24'd0, led_out}, 32'd0);
    check("rst_step",  {31'd0, step_pulse}, 32'd0);
    check("rst_irq",   {31'd0, cycle_irq}, 32'd0);
    check("rst_rdata", read_data, 32'd0);
    bus_read(A_CTRL, rd);   check("rst_ctrl", rd, 32'd0);
    bus_read(A_DIV, rd);    check("rst_div", rd, 32'(DEFAULT_DIV - 1));
    bus_read(A_SEED, rd);   check("rst_seed", rd, 32'h1);
    bus_read(A_STATUS, rd); check("rst_status", rd, 32'h1);

    // Rotate left from reset seed 0x01
    bus_write(A_DIV, 32'd3);
    bus_read(A_DIV, rd); check("div_rb", rd, 32'd3);
    bus_write(A_CTRL, 32'h1);
    exp_pat = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    run_steps("rotl");
    bus_write(A_STATUS, 32'h0001_0000);
    check("rotl_clr_irq", {31'd0, cycle_irq}, 32'd0);
    bus_write(A_CTRL, 32'h0);
    @(posedge clk); #1;
    check("rotl_dis_led", {24'd0, led_out}, 32'd0);
    bus_read(A_STATUS, rd); check("rotl_status", rd, 32'h0000_0001);

    // Rotate right from 0x81
    bus_write(A_SEED, 32'h81);
    bus_write(A_CTRL, 32'h3);
    exp_pat = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
    run_steps("rotr");
    bus_write(A_CTRL, 32'h0);
    bus_read(A_STATUS, rd); check("rotr_status", rd, 32'h0001_0081);
    bus_write(A_STATUS, 32'h0001_0000);
    check("rotr_clr_irq", {31'd0, cycle_irq}, 32'd0);

    // Bounce from 0x01: up to 0x80, back down to 0x01
    bus_write(A_SEED, 32'h01);
    bus_write(A_CTRL, 32'h5);
    exp_pat = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    run_steps("bounce");
    bus_write(A_CTRL, 32'h0);
    bus_read(A_STATUS, rd); check("bounce_status", rd, 32'h0003_0001);
    bus_write(A_STATUS, 32'h0001_0000);
    bus_read(A_STATUS, rd); check("bounce_clr", rd, 32'h0002_0001);

    // Invert; simultaneous re/we returns the pre-write CTRL
    bus_write(A_SEED, 32'h04);
    bus_rw(A_CTRL, 32'h9, rd); check("rw_preval", rd, 32'h0);
    @(posedge clk); #1;
    check("inv_led", {24'd0, led_out}, 32'h0000_00FB);
    bus_write(A_CTRL, 32'h0);
    @(posedge clk); #1;
    check("inv_dis_led", {24'd0, led_out}, 32'd0);
    bus_read(A_STATUS, rd); check("inv_status", rd, 32'h0000_0004);

    // Hold mode with DIV=0: step every cycle, wrap every step, set beats clear
    bus_write(A_DIV, 32'd0);
    bus_write(A_CTRL, 32'h7);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_step", {31'd0, step_pulse}, 32'd1);
    end
    check("hold_led", {24'd0, led_out}, 32'h0000_0004);
    check("hold_irq", {31'd0, cycle_irq}, 32'd1);
    bus_write(A_STATUS, 32'h0001_0000);
    check("set_beats_clr", {31'd0, cycle_irq}, 32'd1);
    bus_write(A_CTRL, 32'h0);
    bus_write(A_STATUS, 32'h0001_0000);
    check("hold_clr_irq", {31'd0, cycle_irq}, 32'd0);
    check("hold_stop", {31'd0, step_pulse}, 32'd0);

    // Prescaler: DIV lowered below count, then SEED write coinciding with a step
    bus_write(A_DIV, 32'd100);
    bus_write(A_SEED, 32'h01);
    bus_write(A_CTRL, 32'h1);
    steps_seen = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (step_pulse) steps_seen++;
    end
    check("div100_nostep", 32'(steps_seen), 32'd0);
    bus_write(A_DIV, 32'd10);
    check("divwr_nostep", {31'd0, step_pulse}, 32'd0);
    @(posedge clk); #1;
    check("divwr_step", {31'd0, step_pulse}, 32'd1);
    repeat (10) @(posedge clk);
    bus_write(A_SEED, 32'h55);
    check("seed_kills_step", {31'd0, step_pulse}, 32'd0);
    bus_read(A_STATUS, rd); check("seed_status", rd, 32'h0000_0055);
    wait_step(gap);
    check("seed_cnt_restart", 32'(gap), 32'd10);
    @(posedge clk); #1;
    check("seed_next_led", {24'd0, led_out}, 32'h0000_00AA);

    // Reset mid-run with a coincident bus write and read
    bus_read(A_STATUS, rd);
    @(negedge clk);
    rst = 1'b1; we = 1'b1; re = 1'b1; address = A_SEED; write_data = 32'h33;
    @(posedge clk); #1;
    rst = 1'b0; we = 1'b0; re = 1'b0;
    check("mrst_led",   {24'd0, led_out}, 32'd0);
    check("mrst_step",  {31'd0, step_pulse}, 32'd0);
    check("mrst_irq",   {31'd0, cycle_irq}, 32'd0);
    check("mrst_rdata", read_data, 32'd0);
    bus_read(A_CTRL, rd);   check("mrst_ctrl", rd, 32'd0);
    bus_read(A_SEED, rd);   check("mrst_seed", rd, 32'h1);
    bus_read(A_STATUS, rd); check("mrst_status", rd, 32'h1);
    bus_read(A_DIV, rd);    check("mrst_div", rd, 32'(DEFAULT_DIV - 1));
    check("mrst_led_idle", {24'd0, led_out}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
